// File: rtl/parking_gate_scheduler_if.sv
// rtl/parking_gate_scheduler_if.sv - request/gate/commit signal bundle between the lot loops, the scheduler and Parking
interface parking_gate_scheduler_if #(
    parameter int TO_CNT_W = 8
);
    logic                entry_req;
    logic                entry_is_uni;
    logic                exit_req;
    logic                exit_is_uni;
    logic                uni_is_vacated_space;
    logic                is_vacated_space;
    logic                car_passed;
    logic                gate_open;
    logic                grant_entry;
    logic                grant_exit;
    logic                car_entered;
    logic                is_uni_car_entered;
    logic                car_exited;
    logic                is_uni_car_exited;
    logic                entry_denied;
    logic [TO_CNT_W-1:0] abort_cnt;

    modport master (
        output entry_req, entry_is_uni, exit_req, exit_is_uni,
               uni_is_vacated_space, is_vacated_space, car_passed,
        input  gate_open, grant_entry, grant_exit, car_entered, is_uni_car_entered,
               car_exited, is_uni_car_exited, entry_denied, abort_cnt
    );

    modport slave (
        input  entry_req, entry_is_uni, exit_req, exit_is_uni,
               uni_is_vacated_space, is_vacated_space, car_passed,
        output gate_open, grant_entry, grant_exit, car_entered, is_uni_car_entered,
               car_exited, is_uni_car_exited, entry_denied, abort_cnt
    );
endinterface

// File: rtl/parking_gate_scheduler.sv
// rtl/parking_gate_scheduler.sv - shared barrier sequencer: arbitration, open/pass/close, commit strobes (option: EXIT_PRIORITY_EN)
module parking_gate_scheduler #(
    parameter int OPEN_CYC     = 4,
    parameter int PASS_TIMEOUT = 16,
    parameter int TO_CNT_W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    parking_gate_scheduler_if.slave  bus
);
    localparam int TMR_MAX = (OPEN_CYC > PASS_TIMEOUT) ? OPEN_CYC : PASS_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OPEN,
        S_WAIT_PASS,
        S_CLOSE
    } state_t;

    state_t              r_state;
    logic [TMR_W-1:0]    r_timer;
    logic                r_req_is_uni;
    logic                r_deny_block;
    logic                r_gate_open;
    logic                r_grant_entry;
    logic                r_grant_exit;
    logic                r_car_entered;
    logic                r_is_uni_car_entered;
    logic                r_car_exited;
    logic                r_is_uni_car_exited;
    logic                r_entry_denied;
    logic [TO_CNT_W-1:0] r_abort_cnt;

    logic w_entry_ok;
    logic w_grant;
    logic w_pick_exit;

    assign w_entry_ok = bus.entry_req &
                        (bus.entry_is_uni ? bus.uni_is_vacated_space : bus.is_vacated_space);
    assign w_grant    = bus.exit_req | w_entry_ok;

`ifdef EXIT_PRIORITY_EN
    assign w_pick_exit = bus.exit_req;
`else
    logic r_rr_last_exit;
    // Contended grant goes to the side that did not win last time.
    assign w_pick_exit = bus.exit_req & (~w_entry_ok | ~r_rr_last_exit);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_last_exit <= 1'b1;
        end else if (r_state == S_IDLE && w_grant) begin
            r_rr_last_exit <= w_pick_exit;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state              <= S_IDLE;
            r_timer              <= '0;
            r_req_is_uni         <= 1'b0;
            r_deny_block         <= 1'b0;
            r_gate_open          <= 1'b0;
            r_grant_entry        <= 1'b0;
            r_grant_exit         <= 1'b0;
            r_car_entered        <= 1'b0;
            r_is_uni_car_entered <= 1'b0;
            r_car_exited         <= 1'b0;
            r_is_uni_car_exited  <= 1'b0;
            r_entry_denied       <= 1'b0;
            r_abort_cnt          <= '0;
        end else begin
            r_car_entered        <= 1'b0;
            r_is_uni_car_entered <= 1'b0;
            r_car_exited         <= 1'b0;
            r_is_uni_car_exited  <= 1'b0;
            r_entry_denied       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!bus.entry_req) begin
                        r_deny_block <= 1'b0;
                    end
                    if (w_grant) begin
                        r_grant_exit  <= w_pick_exit;
                        r_grant_entry <= ~w_pick_exit;
                        r_req_is_uni  <= w_pick_exit ? bus.exit_is_uni : bus.entry_is_uni;
                        r_gate_open   <= 1'b1;
                        r_timer       <= '0;
                        r_state       <= S_OPEN;
                    end else if (bus.entry_req && !r_deny_block) begin
                        // One refusal per arrival; re-armed when the car leaves the loop.
                        r_entry_denied <= 1'b1;
                        r_deny_block   <= 1'b1;
                    end
                end
                S_OPEN: begin
                    if (r_timer == TMR_W'(OPEN_CYC - 1)) begin
                        r_timer <= '0;
                        r_state <= S_WAIT_PASS;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_WAIT_PASS: begin
                    if (bus.car_passed) begin
                        r_car_entered        <= r_grant_entry;
                        r_is_uni_car_entered <= r_grant_entry & r_req_is_uni;
                        r_car_exited         <= r_grant_exit;
                        r_is_uni_car_exited  <= r_grant_exit & r_req_is_uni;
                        r_state              <= S_CLOSE;
                    end else if (r_timer == TMR_W'(PASS_TIMEOUT - 1)) begin
                        if (!(&r_abort_cnt)) begin
                            r_abort_cnt <= r_abort_cnt + 1'b1;
                        end
                        r_state <= S_CLOSE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_CLOSE: begin
                    r_gate_open   <= 1'b0;
                    r_grant_entry <= 1'b0;
                    r_grant_exit  <= 1'b0;
                    r_state       <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.gate_open          = r_gate_open;
    assign bus.grant_entry        = r_grant_entry;
    assign bus.grant_exit         = r_grant_exit;
    assign bus.car_entered        = r_car_entered;
    assign bus.is_uni_car_entered = r_is_uni_car_entered;
    assign bus.car_exited         = r_car_exited;
    assign bus.is_uni_car_exited  = r_is_uni_car_exited;
    assign bus.entry_denied       = r_entry_denied;
    assign bus.abort_cnt          = r_abort_cnt;
endmodule

// File: tb/tb_parking_gate_scheduler.sv
// tb/tb_parking_gate_scheduler.sv - randomized transaction-level bench for parking_gate_scheduler
module tb_parking_gate_scheduler;
    localparam int OPEN_CYC     = 4;
    localparam int PASS_TIMEOUT = 16;
    localparam int TO_CNT_W     = 8;
    localparam int SAT          = (1 << TO_CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    // Reference state: which side won the last grant and the expected abort tally.
    bit   m_rr_exit;
    int   m_abort;

    parking_gate_scheduler_if #(.TO_CNT_W(TO_CNT_W)) bus ();

    parking_gate_scheduler #(
        .OPEN_CYC     (OPEN_CYC),
        .PASS_TIMEOUT (PASS_TIMEOUT),
        .TO_CNT_W     (TO_CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] outs();
        return {bus.gate_open, bus.grant_entry, bus.grant_exit, bus.car_entered,
                bus.is_uni_car_entered, bus.car_exited, bus.is_uni_car_exited, bus.entry_denied};
    endfunction

    function automatic bit model_pick_exit();
        bit entry_ok;
        entry_ok = bus.entry_req && (bus.entry_is_uni ? bus.uni_is_vacated_space : bus.is_vacated_space);
`ifdef EXIT_PRIORITY_EN
        return bus.exit_req;
`else
        if (bus.exit_req && entry_ok) return !m_rr_exit;
        return bus.exit_req;
`endif
    endfunction

    task automatic clear_inputs();
        bus.entry_req = 0; bus.entry_is_uni = 0; bus.exit_req = 0; bus.exit_is_uni = 0;
        bus.uni_is_vacated_space = 0; bus.is_vacated_space = 0; bus.car_passed = 0;
    endtask

    // One full gate cycle starting in IDLE; pass_at outside [0,PASS_TIMEOUT) means no car passes.
    task automatic run_txn(input bit keep_req, input bit toggle_class, input int pass_at, input string name);
        bit   exp_exit, exp_uni, timeout;
        int   t_end;
        logic [7:0] exp_v;
        exp_exit = model_pick_exit();
        exp_uni  = exp_exit ? bus.exit_is_uni : bus.entry_is_uni;
        timeout  = (pass_at < 0) || (pass_at >= PASS_TIMEOUT);
        t_end    = timeout ? OPEN_CYC + PASS_TIMEOUT : OPEN_CYC + pass_at + 1;
        step();
        checks++;
        if ({bus.gate_open, bus.grant_entry, bus.grant_exit} !== {1'b1, !exp_exit, exp_exit}) begin
            $display("FAIL %s_grant got=%b exp=%b", name,
                     {bus.gate_open, bus.grant_entry, bus.grant_exit}, {1'b1, !exp_exit, exp_exit});
            errors++;
            clear_inputs();
            repeat (OPEN_CYC + PASS_TIMEOUT + 4) step();
            return;
        end
        m_rr_exit = exp_exit;
        if (!keep_req) begin
            bus.entry_req = 0;
            bus.exit_req  = 0;
        end
        for (int t = 0; t <= t_end + 1; t++) begin
            bit gate, strobe;
            if (t > 0) step();
            if (t == t_end && timeout) m_abort = (m_abort >= SAT) ? SAT : m_abort + 1;
            gate   = (t <= t_end);
            strobe = (t == t_end) && !timeout;
            exp_v  = {gate, gate && !exp_exit, gate && exp_exit,
                      strobe && !exp_exit, strobe && !exp_exit && exp_uni,
                      strobe && exp_exit, strobe && exp_exit && exp_uni, 1'b0};
            checks++;
            if (outs() !== exp_v || int'(bus.abort_cnt) != m_abort) begin
                $display("FAIL %s t=%0d outs got=%b exp=%b abort got=%0d exp=%0d",
                         name, t, outs(), exp_v, bus.abort_cnt, m_abort);
                errors++;
            end
            if (!timeout && t == OPEN_CYC + pass_at) bus.car_passed = 1;
            else if (t < OPEN_CYC)                    bus.car_passed = 1'($urandom_range(0, 1));
            else                                      bus.car_passed = 0;
            if (toggle_class && t < t_end) begin
                bus.entry_is_uni = 1'($urandom_range(0, 1));
                bus.exit_is_uni  = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        bus.entry_req = 1; bus.exit_req = 1; bus.car_passed = 1;
        bus.uni_is_vacated_space = 1; bus.is_vacated_space = 1;
        repeat (2) step();
        m_rr_exit = 1; m_abort = 0;
        checks++;
        if (outs() !== 8'h00 || bus.abort_cnt !== '0) begin
            $display("FAIL reset outs got=%b abort=%0d exp=0", outs(), bus.abort_cnt);
            errors++;
        end
        clear_inputs();
        rst_n = 1;
        step();
    endtask

    task automatic test_uni_entry();
        bus.entry_req = 1; bus.entry_is_uni = 1; bus.uni_is_vacated_space = 1;
        bus.is_vacated_space = 1'($urandom_range(0, 1));
        run_txn(0, 0, 2, "uni_entry");
    endtask

    task automatic test_deny();
        bit cls;
        logic [7:0] exp_v;
        cls = 1'($urandom_range(0, 1));
        bus.entry_is_uni = cls;
        bus.uni_is_vacated_space = cls ? 1'b0 : 1'($urandom_range(0, 1));
        bus.is_vacated_space     = cls ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.exit_req = 0;
        bus.entry_req = 1;
        for (int s = 1; s <= 8; s++) begin
            step();
            exp_v = {7'b0, s == 1};
            checks++;
            if (outs() !== exp_v) begin
                $display("FAIL deny s=%0d got=%b exp=%b", s, outs(), exp_v);
                errors++;
            end
        end
        bus.entry_req = 0;
        step();
        bus.entry_req = 1;
        step();
        checks++;
        if (outs() !== 8'b0000_0001) begin
            $display("FAIL deny_rearm got=%b exp=00000001", outs());
            errors++;
        end
        bus.entry_req = 0;
        step();
    endtask

    task automatic test_round_robin();
        bus.entry_is_uni = 1'($urandom_range(0, 1));
        bus.uni_is_vacated_space = 1; bus.is_vacated_space = 1;
        bus.exit_is_uni = 1'($urandom_range(0, 1));
        bus.entry_req = 1; bus.exit_req = 1;
        for (int i = 0; i < 4; i++) begin
            bit want_exit;
`ifdef EXIT_PRIORITY_EN
            want_exit = 1;
`else
            want_exit = (i % 2 == 0);
`endif
            checks++;
            if (model_pick_exit() !== want_exit) begin
                $display("FAIL rr_order i=%0d model=%b exp=%b", i, model_pick_exit(), want_exit);
                errors++;
            end
            run_txn(1, 0, int'($urandom_range(0, PASS_TIMEOUT - 1)), "round_robin");
        end
        bus.entry_req = 0; bus.exit_req = 0;
        step();
    endtask

    task automatic test_timeout();
        bus.entry_req = 0; bus.exit_req = 1;
        bus.exit_is_uni = 1'($urandom_range(0, 1));
        run_txn(1, 0, -1, "timeout_first");
        checks++;
        if (bus.abort_cnt !== TO_CNT_W'(1)) begin
            $display("FAIL abort_first got=%0d exp=1", bus.abort_cnt);
            errors++;
        end
        for (int i = 0; i < 300; i++) run_txn(i != 299, 0, -1, "timeout_sat");
        checks++;
        if (int'(bus.abort_cnt) != SAT) begin
            $display("FAIL abort_sat got=%0d exp=%0d", bus.abort_cnt, SAT);
            errors++;
        end
        step();
    endtask

    task automatic test_reset_mid();
        bus.entry_req = 1; bus.entry_is_uni = 0; bus.is_vacated_space = 1;
        step();
        checks++;
        if (bus.grant_entry !== 1'b1) begin
            $display("FAIL mid_grant got=%b exp=1", bus.grant_entry);
            errors++;
        end
        bus.entry_req = 0;
        repeat (OPEN_CYC + 2) step();
        rst_n = 0;
        bus.car_passed = 1;
        step();
        m_rr_exit = 1; m_abort = 0;
        checks++;
        if (outs() !== 8'h00 || bus.abort_cnt !== '0) begin
            $display("FAIL mid_reset outs got=%b abort=%0d exp=0", outs(), bus.abort_cnt);
            errors++;
        end
        rst_n = 1;
        bus.car_passed = 0;
        step();
        checks++;
        if (outs() !== 8'h00) begin
            $display("FAIL mid_after got=%b exp=00000000", outs());
            errors++;
        end
    endtask

    task automatic test_class_latch();
        bus.uni_is_vacated_space = 1; bus.is_vacated_space = 1;
        for (int i = 0; i < 4; i++) begin
            bus.entry_req = 1;
            bus.entry_is_uni = 1'($urandom_range(0, 1));
            run_txn(0, 1, int'($urandom_range(0, PASS_TIMEOUT - 1)), "class_latch");
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            bit entry_ok;
            bus.entry_req            = 1'($urandom_range(0, 1));
            bus.entry_is_uni         = 1'($urandom_range(0, 1));
            bus.exit_req             = 1'($urandom_range(0, 1));
            bus.exit_is_uni          = 1'($urandom_range(0, 1));
            bus.uni_is_vacated_space = 1'($urandom_range(0, 1));
            bus.is_vacated_space     = 1'($urandom_range(0, 1));
            entry_ok = bus.entry_req && (bus.entry_is_uni ? bus.uni_is_vacated_space : bus.is_vacated_space);
            if (!bus.exit_req && !entry_ok) bus.exit_req = 1;
            run_txn(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, PASS_TIMEOUT)), "random");
        end
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        test_reset();
        test_uni_entry();
        test_deny();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_class_latch();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
